// File: rtl/bram_stream_pkg.sv
// Shared constants, field positions and FSM encoding for the BRAM stream command scheduler.
package bram_stream_pkg;

    localparam logic [1:0] RMODE = 2'b01;
    localparam logic [1:0] WMODE = 2'b00;

    localparam int WSW_BIT = 33;
    localparam int MODE_HI = 31;
    localparam int MODE_LO = 30;
    localparam int ADDR_HI = 29;
    localparam int ADDR_LO = 15;
    localparam int LEN_HI  = 14;

    localparam int BANK_DEPTH = 12544;
    localparam int DEPTH      = 2 * BANK_DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_RUN
    } state_t;

    // The address/length sum is taken one bit wider so the end address cannot wrap.
    function automatic logic cmdInvalid(input logic [1:0]  mode,
                                        input logic [14:0] addr,
                                        input logic [14:0] len);
        logic [15:0] sum;
        sum = {1'b0, addr} + {1'b0, len};
        return ((mode != RMODE) && (mode != WMODE)) || (len == 15'd0) || (sum > 16'(DEPTH));
    endfunction

endpackage

// File: rtl/bram_stream_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_grant,
    output logic       o_idx
);

    logic r_prio;

    always_comb begin
        o_idx   = 1'b0;
        o_grant = 2'b00;
        if (i_req == 2'b11) begin
            o_idx = r_prio;
        end else begin
            o_idx = i_req[1];
        end
        if (i_en && (i_req != 2'b00)) begin
            o_grant = o_idx ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (o_grant != 2'b00) begin
            r_prio <= ~o_idx;
        end
    end

endmodule

// File: rtl/bram_stream_scheduler.sv
// Two-requester command scheduler issuing 64-bit instructions to the BRAM stream interface.
// Optional RUN watchdog and sticky timeout_flag port: define BRAM_STREAM_SCHED_TIMEOUT_EN.
module bram_stream_scheduler
    import bram_stream_pkg::*;
`ifdef BRAM_STREAM_SCHED_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = 65535
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_cmd0,
    input  logic [63:0] req_cmd1,
    output logic [1:0]  req_done,
    output logic [1:0]  req_err,
    output logic [63:0] m_instruct_tdata,
    output logic        m_instruct_tvalid,
    input  logic        m_instruct_tready,
    input  logic        mon_out_tvalid,
    input  logic        mon_out_tready,
    input  logic        mon_out_tlast,
    input  logic        mon_in_tvalid,
    input  logic        mon_in_tready,
    input  logic        mon_in_tlast,
    output logic        busy,
    output logic        owner
`ifdef BRAM_STREAM_SCHED_TIMEOUT_EN
    ,
    output logic        timeout_flag
`endif
);

    state_t      r_state;
    state_t      w_next;
    logic        r_busy;
    logic        r_owner;
    logic        r_wsw;
    logic [1:0]  r_mode;
    logic [14:0] r_addr;
    logic [14:0] r_len;
    logic [1:0]  r_done;
    logic [1:0]  r_err;

    logic        w_grantEn;
    logic [1:0]  w_grant;
    logic        w_grantIdx;
    logic [63:0] w_selCmd;
    logic        w_chkBad;
    logic        w_tlastHit;
    logic        w_timeout;
    logic        w_unused;

    // No grant while a done/err pulse is out, so instructions are separated by an idle cycle.
    assign w_grantEn = (r_state == ST_IDLE) && (r_done == 2'b00) && (r_err == 2'b00);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (req_valid),
        .i_en    (w_grantEn),
        .o_grant (w_grant),
        .o_idx   (w_grantIdx)
    );

    assign w_selCmd = w_grantIdx ? req_cmd1 : req_cmd0;
    assign w_unused = ^{w_selCmd[63:WSW_BIT+1], w_selCmd[WSW_BIT-1]};
    assign w_chkBad = cmdInvalid(r_mode, r_addr, r_len);

    assign w_tlastHit = (r_state == ST_RUN) &&
                        ((r_mode == RMODE) ? (mon_out_tvalid && mon_out_tready && mon_out_tlast)
                                           : (mon_in_tvalid && mon_in_tready && mon_in_tlast));

`ifdef BRAM_STREAM_SCHED_TIMEOUT_EN
    logic [15:0] r_wdog;
    logic        r_timeoutFlag;
    logic        w_wdogHit;

    assign w_wdogHit    = (r_wdog == 16'(TIMEOUT - 1));
    assign w_timeout    = (r_state == ST_RUN) && !w_tlastHit && w_wdogHit;
    assign timeout_flag = r_timeoutFlag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog        <= 16'd0;
            r_timeoutFlag <= 1'b0;
        end else if ((r_state == ST_RUN) && !w_tlastHit && !w_wdogHit) begin
            r_wdog <= r_wdog + 16'd1;
        end else begin
            r_wdog <= 16'd0;
            if (w_timeout) begin
                r_timeoutFlag <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant != 2'b00) w_next = ST_CHECK;
            ST_CHECK: w_next = w_chkBad ? ST_IDLE : ST_ISSUE;
            ST_ISSUE: if (m_instruct_tready) w_next = ST_RUN;
            ST_RUN:   if (w_tlastHit || w_timeout) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_owner <= 1'b0;
            r_wsw   <= 1'b0;
            r_mode  <= 2'b00;
            r_addr  <= 15'd0;
            r_len   <= 15'd0;
            r_done  <= 2'b00;
            r_err   <= 2'b00;
        end else begin
            r_done <= 2'b00;
            r_err  <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_busy  <= 1'b1;
                        r_owner <= w_grantIdx;
                        r_wsw   <= w_selCmd[WSW_BIT];
                        r_mode  <= w_selCmd[MODE_HI:MODE_LO];
                        r_addr  <= w_selCmd[ADDR_HI:ADDR_LO];
                        r_len   <= w_selCmd[LEN_HI:0];
                    end
                end
                ST_CHECK: begin
                    if (w_chkBad) begin
                        r_err[r_owner] <= 1'b1;
                        r_busy         <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_tlastHit) begin
                        r_done[r_owner] <= 1'b1;
                        r_busy          <= 1'b0;
                    end else if (w_timeout) begin
                        r_err[r_owner] <= 1'b1;
                        r_busy         <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_instruct_tvalid = (r_state == ST_ISSUE);
    assign m_instruct_tdata  = (r_state == ST_ISSUE) ?
                               {30'd0, r_wsw, 1'b0, r_mode, r_addr, r_len} : 64'd0;
    assign req_ready = w_grant;
    assign req_done  = r_done;
    assign req_err   = r_err;
    assign busy      = r_busy;
    assign owner     = r_owner;

endmodule

// File: tb/tb_bram_stream_scheduler.sv
// Directed, table-driven bench for bram_stream_scheduler.
module tb_bram_stream_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_cmd0;
    logic [63:0] req_cmd1;
    logic [1:0]  req_done;
    logic [1:0]  req_err;
    logic [63:0] m_instruct_tdata;
    logic        m_instruct_tvalid;
    logic        m_instruct_tready;
    logic        mon_out_tvalid, mon_out_tready, mon_out_tlast;
    logic        mon_in_tvalid, mon_in_tready, mon_in_tlast;
    logic        busy;
    logic        owner;
`ifdef BRAM_STREAM_SCHED_TIMEOUT_EN
    logic        timeoutFlag;
`endif

    int testCount = 0;
    int failCount = 0;
    int hsCount   = 0;

    localparam logic [63:0] C0 = 64'h0000_0000_4000_0004;
    localparam logic [63:0] C1 = 64'h0000_0000_4032_0005;
    localparam logic [63:0] C2 = 64'h0000_0000_30FC_0008;

    typedef struct {
        logic        reqIdx;
        logic [63:0] cmd;
        logic        expErr;
        logic [63:0] expData;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_instruct_tvalid && m_instruct_tready) hsCount++;
    end

`ifdef BRAM_STREAM_SCHED_TIMEOUT_EN
    bram_stream_scheduler #(.TIMEOUT(100)) dut (
`else
    bram_stream_scheduler dut (
`endif
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_cmd0          (req_cmd0),
        .req_cmd1          (req_cmd1),
        .req_done          (req_done),
        .req_err           (req_err),
        .m_instruct_tdata  (m_instruct_tdata),
        .m_instruct_tvalid (m_instruct_tvalid),
        .m_instruct_tready (m_instruct_tready),
        .mon_out_tvalid    (mon_out_tvalid),
        .mon_out_tready    (mon_out_tready),
        .mon_out_tlast     (mon_out_tlast),
        .mon_in_tvalid     (mon_in_tvalid),
        .mon_in_tready     (mon_in_tready),
        .mon_in_tlast      (mon_in_tlast),
        .busy              (busy),
        .owner             (owner)
`ifdef BRAM_STREAM_SCHED_TIMEOUT_EN
        ,
        .timeout_flag      (timeoutFlag)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic isOut, input logic last);
        if (isOut) begin
            mon_out_tvalid = 1'b1; mon_out_tready = 1'b1; mon_out_tlast = last;
        end else begin
            mon_in_tvalid = 1'b1; mon_in_tready = 1'b1; mon_in_tlast = last;
        end
        tick();
        mon_out_tvalid = 1'b0; mon_out_tready = 1'b0; mon_out_tlast = 1'b0;
        mon_in_tvalid  = 1'b0; mon_in_tready  = 1'b0; mon_in_tlast  = 1'b0;
    endtask

    // Called in RUN; finishes with the done pulse gone and the scheduler idle.
    task automatic completeRun(input logic isRead, input int nBeats, input logic idx);
        logic [1:0] oh;
        oh = idx ? 2'b10 : 2'b01;
        for (int i = 0; i < nBeats - 1; i++) beat(isRead, 1'b0);
        checkOutput("done_before_last", req_done, 2'b00);
        beat(isRead, 1'b1);
        checkOutput("done_pulse", req_done, oh);
        checkOutput("busy_at_done", busy, 1'b0);
        checkOutput("no_grant_at_done", req_ready, 2'b00);
        tick();
        checkOutput("done_cleared", req_done, 2'b00);
    endtask

    task automatic handshake();
        m_instruct_tready = 1'b1;
        tick();
        m_instruct_tready = 1'b0;
        checkOutput("tvalid_after_hs", m_instruct_tvalid, 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [1:0] oh;
        oh = v.reqIdx ? 2'b10 : 2'b01;
        if (v.reqIdx) req_cmd1 = v.cmd; else req_cmd0 = v.cmd;
        req_valid = oh;
        #1;
        checkOutput("vec_ready", req_ready, oh);
        tick();
        req_valid = 2'b00;
        checkOutput("vec_busy", busy, 1'b1);
        checkOutput("vec_owner", owner, v.reqIdx);
        checkOutput("vec_tvalid_check", m_instruct_tvalid, 1'b0);
        tick();
        if (v.expErr) begin
            checkOutput("vec_err", req_err, oh);
            checkOutput("vec_err_tvalid", m_instruct_tvalid, 1'b0);
            checkOutput("vec_err_busy", busy, 1'b0);
            tick();
            checkOutput("vec_err_cleared", req_err, 2'b00);
            checkOutput("vec_err_tvalid2", m_instruct_tvalid, 1'b0);
        end else begin
            checkOutput("vec_tvalid", m_instruct_tvalid, 1'b1);
            checkOutput("vec_tdata", m_instruct_tdata, v.expData);
            handshake();
            completeRun(v.expData[31:30] == 2'b01, 3, v.reqIdx);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, C0, 1'b0, C0};
        vecs[1] = '{1'b1, 64'h0000_0000_30FC_0009, 1'b1, 64'd0};
        vecs[2] = '{1'b1, C2, 1'b0, C2};
        vecs[3] = '{1'b0, 64'hABCD_1237_4000_0010, 1'b0, 64'h0000_0002_4000_0010};
        vecs[4] = '{1'b0, 64'h0000_0000_8000_0004, 1'b1, 64'd0};
        vecs[5] = '{1'b1, 64'h0000_0000_4000_0000, 1'b1, 64'd0};
        vecs[6] = '{1'b1, 64'hFFFF_FFFC_4032_0005, 1'b0, C1};
        vecs[7] = '{1'b0, 64'h0000_0000_C000_0001, 1'b1, 64'd0};
        vecs[8] = '{1'b0, 64'h0000_0000_7FFF_8001, 1'b1, 64'd0};

        rst_n = 1'b0;
        req_valid = 2'b00; req_cmd0 = 64'd0; req_cmd1 = 64'd0;
        m_instruct_tready = 1'b0;
        mon_out_tvalid = 1'b0; mon_out_tready = 1'b0; mon_out_tlast = 1'b0;
        mon_in_tvalid  = 1'b0; mon_in_tready  = 1'b0; mon_in_tlast  = 1'b0;
        tick(); tick();
        checkOutput("rst_ready", req_ready, 2'b00);
        checkOutput("rst_done", req_done, 2'b00);
        checkOutput("rst_err", req_err, 2'b00);
        checkOutput("rst_tvalid", m_instruct_tvalid, 1'b0);
        checkOutput("rst_tdata", m_instruct_tdata, 64'd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_owner", owner, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Stray tlast while idle must be ignored
        beat(1'b1, 1'b1);
        checkOutput("idle_stray_done", req_done, 2'b00);
        checkOutput("idle_stray_busy", busy, 1'b0);

        // Contention: req0 first, req1 after done plus gap, then req1 wins the next tie
        req_cmd0 = C0; req_cmd1 = C1; req_valid = 2'b11;
        #1;
        checkOutput("contend_ready0", req_ready, 2'b01);
        tick();
        req_valid[0] = 1'b0;
        checkOutput("contend_wait_check", req_ready, 2'b00);
        checkOutput("contend_owner0", owner, 1'b0);
        tick();
        checkOutput("contend_tdata0", m_instruct_tdata, C0);
        checkOutput("contend_wait_issue", req_ready, 2'b00);
        handshake();
        req_cmd0 = C2; req_valid[0] = 1'b1;
        #1;
        checkOutput("contend_wait_run", req_ready, 2'b00);
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        checkOutput("contend_done0", req_done, 2'b01);
        checkOutput("contend_gap", req_ready, 2'b00);
        tick();
        checkOutput("contend_ready1", req_ready, 2'b10);
        tick();
        req_valid[1] = 1'b0;
        checkOutput("contend_owner1", owner, 1'b1);
        tick();
        checkOutput("contend_tdata1", m_instruct_tdata, C1);
        handshake();
        completeRun(1'b1, 5, 1'b1);
        checkOutput("contend_ready0_again", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        checkOutput("contend_tdata2", m_instruct_tdata, C2);
        handshake();
        completeRun(1'b0, 2, 1'b0);

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

        // tready held low: instruction must stay stable, one handshake; stray mon_in tlast ignored
        req_cmd0 = C0; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        begin
            int hsStart;
            hsStart = hsCount;
            for (int i = 0; i < 5; i++) begin
                checkOutput("stall_tvalid", m_instruct_tvalid, 1'b1);
                checkOutput("stall_tdata", m_instruct_tdata, C0);
                tick();
            end
            handshake();
            tick();
            checkOutput("stall_hs_count", 64'(hsCount - hsStart), 64'd1);
        end
        beat(1'b0, 1'b1);
        checkOutput("stray_in_done", req_done, 2'b00);
        checkOutput("stray_in_busy", busy, 1'b1);
        completeRun(1'b1, 4, 1'b0);

        // Async reset during RUN
        req_cmd1 = C1; req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        handshake();
        beat(1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_owner", owner, 1'b0);
        checkOutput("arst_tvalid", m_instruct_tvalid, 1'b0);
        checkOutput("arst_done", req_done, 2'b00);
        checkOutput("arst_err", req_err, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("arst_post_done", req_done, 2'b00);
        checkOutput("arst_post_err", req_err, 2'b00);
        applyStimulus(vecs[0]);

`ifdef BRAM_STREAM_SCHED_TIMEOUT_EN
        // Watchdog: no tlast, error at the 100th RUN cycle
        req_cmd0 = C0; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        handshake();
        for (int i = 0; i < 99; i++) tick();
        checkOutput("wdog_early_err", req_err, 2'b00);
        checkOutput("wdog_early_flag", timeoutFlag, 1'b0);
        tick();
        checkOutput("wdog_err", req_err, 2'b01);
        checkOutput("wdog_done", req_done, 2'b00);
        checkOutput("wdog_busy", busy, 1'b0);
        checkOutput("wdog_flag", timeoutFlag, 1'b1);
        tick();
        checkOutput("wdog_flag_sticky", timeoutFlag, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
